// File: rtl/clk_gate_pkg.sv
// Shared types for the clock-gate enable controller.
//   cg_state_e  : controller states (RUN, IDLE, OFF, WAKE)
//   GATED_CNT_W : width of the optional gated-cycle counter (GATED_CNT_EN)
package clk_gate_pkg;

  typedef enum logic [1:0] {
    CG_RUN  = 2'd0,
    CG_IDLE = 2'd1,
    CG_OFF  = 2'd2,
    CG_WAKE = 2'd3
  } cg_state_e;

  localparam int unsigned GATED_CNT_W = 32;

endpackage

// File: rtl/clk_gate_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (count -> 0)
//   clr_i  : synchronous clear, wins over inc_i
//   inc_i  : increment by one, holds at all-ones
//   cnt_o  : current count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Upstream enable controller for a clk_gate cell. Gates the downstream clock
// after timeout_i idle samples and brings it back with a wake-up handshake.
// Optional feature macro: GATED_CNT_EN (adds gated_cnt_o / clr_cnt_i).
// Ports:
//   clk_i       : free-running clock
//   rst_i       : synchronous active-high reset
//   req_i       : activity request, held until req_i & ready_o
//   busy_i      : downstream busy (ignored while gated)
//   force_on_i  : keep / bring the clock on
//   timeout_i   : idle samples before gating, 0 disables gating
//   en_o        : registered enable to clk_gate e_i
//   ready_o     : gated domain clocked and usable
//   gated_cnt_o : [GATED_CNT_EN] cycles with en_o == 0, saturating
//   clr_cnt_i   : [GATED_CNT_EN] synchronous clear of gated_cnt_o
//
// state | meaning
// RUN   | clock on, no idle seen
// IDLE  | clock on, counting consecutive idle samples
// OFF   | clock gated
// WAKE  | clock re-enabled, waiting WAKE_CYCLES before ready
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic                   busy_i,
  input  logic                   force_on_i,
  input  logic [CNT_W-1:0]       timeout_i,
`ifdef GATED_CNT_EN
  output logic [GATED_CNT_W-1:0] gated_cnt_o,
  input  logic                   clr_cnt_i,
`endif
  output logic                   en_o,
  output logic                   ready_o
);

  localparam int unsigned WAKE_LAST = (WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0;
  localparam int unsigned WAKE_W    = (WAKE_LAST > 0) ? $clog2(WAKE_LAST + 1) : 1;
  localparam logic [WAKE_W-1:0] WAKE_LAST_V = WAKE_LAST[WAKE_W-1:0];

  cg_state_e          state;
  logic               idle;
  logic               gate_on;
  logic               idle_inc;
  logic               wake_inc;
  logic               wake_done;
  logic [CNT_W-1:0]   idle_cnt;
  logic [WAKE_W-1:0]  wake_cnt;

  assign idle    = !req_i && !busy_i && !force_on_i;
  assign gate_on = (timeout_i != '0);

  // idle_cnt only advances while idle is accumulating toward the timeout;
  // every other case (activity, gating, OFF, WAKE) parks it at zero.
  assign idle_inc = idle && gate_on &&
                    ((state == CG_RUN) ||
                     ((state == CG_IDLE) && (idle_cnt < timeout_i)));

  assign wake_inc  = (state == CG_WAKE);
  assign wake_done = (wake_cnt == WAKE_LAST_V);

  sat_counter #(.W(CNT_W)) u_idle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (!idle_inc),
    .inc_i (idle_inc),
    .cnt_o (idle_cnt)
  );

  sat_counter #(.W(WAKE_W)) u_wake_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (!wake_inc || wake_done),
    .inc_i (wake_inc),
    .cnt_o (wake_cnt)
  );

`ifdef GATED_CNT_EN
  sat_counter #(.W(GATED_CNT_W)) u_gated_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_cnt_i),
    .inc_i (!en_o),
    .cnt_o (gated_cnt_o)
  );
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= CG_RUN;
      en_o    <= 1'b1;
      ready_o <= 1'b1;
    end else begin
      case (state)
        CG_RUN: begin
          en_o    <= 1'b1;
          ready_o <= 1'b1;
          if (idle && gate_on) state <= CG_IDLE;
        end
        CG_IDLE: begin
          // Activity (or gating disabled) beats a simultaneous timeout hit.
          if (!idle || !gate_on) begin
            state   <= CG_RUN;
            en_o    <= 1'b1;
            ready_o <= 1'b1;
          end else if (idle_cnt >= timeout_i) begin
            state   <= CG_OFF;
            en_o    <= 1'b0;
            ready_o <= 1'b0;
          end
        end
        CG_OFF: begin
          if (req_i || force_on_i) begin
            en_o <= 1'b1;
            if (WAKE_CYCLES == 0) begin
              state   <= CG_RUN;
              ready_o <= 1'b1;
            end else begin
              state   <= CG_WAKE;
              ready_o <= 1'b0;
            end
          end
        end
        CG_WAKE: begin
          en_o <= 1'b1;
          if (wake_done) begin
            state   <= CG_RUN;
            ready_o <= 1'b1;
          end
        end
        default: begin
          state   <= CG_RUN;
          en_o    <= 1'b1;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
